// File: rtl/adder_pkg.sv
// Shared constants for the clocked full adder: width limit and reset values.
package adder_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  localparam logic [FA_MAX_WIDTH-1:0] FA_SUM_RST   = '0;
  localparam logic                    FA_CARRY_RST = 1'b0;

  // Legal operand widths are 1..FA_MAX_WIDTH inclusive.
  function automatic logic fa_width_ok(input int unsigned w);
    return (w >= 1) && (w <= FA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder; one stage of the ripple chain.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s_c,
  output logic o_cout_c
);

  logic w_p;

  assign w_p      = i_a ^ i_b;
  assign o_s_c    = w_p ^ i_cin;
  assign o_cout_c = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/full_adder.sv
// Clocked WIDTH-bit adder: ripple of fa_cell stages feeding a sync-reset
// output register, so {carry, sum} = a + b + c one cycle after sampling.
module full_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  if (!fa_width_ok(WIDTH)) begin : g_bad_width
    $error("full_adder: WIDTH must be in 1..%0d", FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  assign w_k[0] = c;

  // Carry ripples from bit 0 upward; w_k[WIDTH] is the carry-out.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    fa_cell u_cell (
      .i_a      (a[gi]),
      .i_b      (b[gi]),
      .i_cin    (w_k[gi]),
      .o_s_c    (w_sum[gi]),
      .o_cout_c (w_k[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= WIDTH'(FA_SUM_RST);
      r_carry <= FA_CARRY_RST;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_k[WIDTH];
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 8 against an
// arithmetic reference (a + b + c), with reset and mid-cycle stability checks.
module tb_full_adder;

  logic       clk;
  logic       rst;
  logic       a1, b1, c1, sum1, carry1;
  logic [3:0] a4, b4, sum4;
  logic       c4, carry4;
  logic [7:0] a8, b8, sum8;
  logic       c8, carry8;

  int unsigned n_vec;
  int unsigned n_err;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .sum(sum1), .carry(carry1)
  );
  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .sum(sum4), .carry(carry4)
  );
  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .sum(sum8), .carry(carry8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic z);
    return x + y + 64'(z);
  endfunction

  logic [63:0] exp1, exp4, exp8;
  logic [2:0]  v;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; c8 = 1'b0;

    // Reset holds outputs at zero despite all-ones inputs.
    tick();
    tick();
    check_eq("rst_w1", 64'({carry1, sum1}), 64'd0);
    check_eq("rst_w4", 64'({carry4, sum4}), 64'd0);
    check_eq("rst_w8", 64'({carry8, sum8}), 64'd0);

    // First edge after release loads the pending inputs: no dead cycle.
    rst = 1'b0;
    tick();
    check_eq("rst_release_w1", 64'({carry1, sum1}), 64'b11);

    // WIDTH=1 exhaustive, a is the MSB of the stimulus index.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, c1} = v;
      exp1 = ref_add(64'(v[2]), 64'(v[1]), v[0]);
      tick();
      check_eq($sformatf("exh_w1_%0d", i), 64'({carry1, sum1}), exp1);
    end

    // Mid-stream reset discards the in-flight result.
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    tick();
    check_eq("mid_pre_w1", 64'({carry1, sum1}), 64'b01);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("mid_rst_w1", 64'({carry1, sum1}), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("mid_post_w1", 64'({carry1, sum1}), 64'b10);

    // WIDTH=4 carry ripple across every bit.
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    check_eq("ripple_f_0_1", 64'({carry4, sum4}), 64'h10);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    check_eq("ripple_f_f_1", 64'({carry4, sum4}), 64'h1F);

    // Random streams, one operand set per cycle on all three widths.
    for (int i = 0; i < 1000; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      exp1 = ref_add(64'(a1), 64'(b1), c1);
      exp4 = ref_add(64'(a4), 64'(b4), c4);
      exp8 = ref_add(64'(a8), 64'(b8), c8);
      tick();
      check_eq("rand_w8", 64'({carry8, sum8}), exp8);
      if ((i % 50) == 0) begin
        check_eq("rand_w4", 64'({carry4, sum4}), exp4);
        check_eq("rand_w1", 64'({carry1, sum1}), exp1);
      end
    end

    // Toggling inputs between edges must not disturb the registered outputs.
    a8 = 8'hC3; b8 = 8'h5A; c8 = 1'b1;
    exp8 = ref_add(64'(a8), 64'(b8), c8);
    tick();
    check_eq("stable_base", 64'({carry8, sum8}), exp8);
    #2 a8 = 8'hFF;
    #1 check_eq("stable_tog1", 64'({carry8, sum8}), exp8);
    #1 a8 = 8'h00;
    #1 check_eq("stable_tog2", 64'({carry8, sum8}), exp8);
    exp8 = ref_add(64'(a8), 64'(b8), c8);
    tick();
    check_eq("stable_next", 64'({carry8, sum8}), exp8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
